// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined carry adder: segment sizing and the full-adder cell.
// The stage payload struct lives in the adder module because its field widths follow each instance's WIDTH.
package adder_pkg;

  function automatic int seg_count(input int width, input int stages);
    return width / stages;
  endfunction

  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple adder built from chained full-adder cells.
module adder_segment
  import adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic       carry;
  logic [1:0] fa;

  always_comb begin
    carry = cin;
    fa    = '0;
    sum   = '0;
    for (int i = 0; i < SEG; i++) begin
      fa     = full_add(a[i], b[i], carry);
      sum[i] = fa[0];
      carry  = fa[1];
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/subtract split into STAGES registered ripple segments with a valid/ready handshake.
// Optional signed-overflow output ovf is built when OVERFLOW_FLAG_EN is defined.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG  = seg_count(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("pipelined_carry_adder: WIDTH must be at least 2");
    end
    if (STAGES < 1) begin : g_bad_stages
      $error("pipelined_carry_adder: STAGES must be at least 1");
    end else if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // sum_lo fills from the bottom as segments complete; a_hi/b_hi carry the operands
  // forward so later segments can read their slice.
  typedef struct packed {
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic             carry;
    logic             valid;
  } stage_t;

  stage_t         st_q     [STAGES];
  stage_t         st_d     [STAGES];
  stage_t         st_in    [STAGES];
  logic [SEG-1:0] seg_sum  [STAGES];
  logic           seg_cout [STAGES];
  logic           stall;

  assign out_valid = st_q[LAST].valid;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign sum       = st_q[LAST].sum_lo;
  assign cout      = st_q[LAST].carry;

  // Subtraction is A + ~B + ~cin, so conditioning happens once at the pipeline entry.
  always_comb begin
    st_in[0]       = '0;
    st_in[0].a_hi  = a;
    st_in[0].b_hi  = sub ? ~b : b;
    st_in[0].carry = sub ? ~cin : cin;
    st_in[0].valid = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_in[k] = st_q[k-1];
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_seg
      adder_segment #(
        .SEG(SEG)
      ) u_seg (
        .a   (st_in[k].a_hi[k*SEG +: SEG]),
        .b   (st_in[k].b_hi[k*SEG +: SEG]),
        .cin (st_in[k].carry),
        .sum (seg_sum[k]),
        .cout(seg_cout[k])
      );
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k]                     = st_in[k];
      st_d[k].sum_lo[k*SEG +: SEG] = seg_sum[k];
      st_d[k].carry               = seg_cout[k];
      if (k == LAST) begin
        st_d[k].a_hi = '0;
        st_d[k].b_hi = '0;
      end
      if (stall) begin
        st_d[k] = st_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  // Operands are not needed once the last segment has consumed them.
  logic unused_ok;
  assign unused_ok = ^{st_q[LAST].a_hi, st_q[LAST].b_hi};

`ifdef OVERFLOW_FLAG_EN
  logic ovf_d;
  logic ovf_q;

  // Sign bits ride along in a_hi/b_hi; the result MSB is the top bit of the last segment.
  always_comb begin
    ovf_d = (st_in[LAST].a_hi[WIDTH-1] == st_in[LAST].b_hi[WIDTH-1]) &&
            (seg_sum[LAST][SEG-1] != st_in[LAST].a_hi[WIDTH-1]);
    if (stall) begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Randomized and directed bench for pipelined_carry_adder against an arithmetic reference queue.
// Exercises the ovf output as well when OVERFLOW_FLAG_EN is defined.
module tb_pipelined_carry_adder;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W8 = 8;
  localparam int S8 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;

  logic          d8_in_valid, d8_in_ready, d8_cin, d8_sub, d8_out_valid, d8_out_ready, d8_cout;
  logic [W8-1:0] d8_a, d8_b, d8_sum;

`ifdef OVERFLOW_FLAG_EN
  logic ovf, d8_ovf;
`endif

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf)
`endif
  );

  pipelined_carry_adder #(.WIDTH(W8), .STAGES(S8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .a(d8_a), .b(d8_b), .cin(d8_cin), .sub(d8_sub),
    .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .sum(d8_sum), .cout(d8_cout)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(d8_ovf)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];

  // Plain integer arithmetic: add is a+b+cin, subtract is a-b-cin with cout = no borrow.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    res_t            r;
    longint unsigned ua, ub, uc, t;
    longint          sa, sb, sc, sr;
    ua = ma; ub = mb; uc = mc;
    sa = $signed(ma); sb = $signed(mb); sc = mc;
    if (!ms) begin
      t      = ua + ub + uc;
      r.sum  = t[W-1:0];
      r.cout = (t >> W) != 0;
      sr     = sa + sb + sc;
    end else begin
      t      = ua - ub - uc;
      r.sum  = t[W-1:0];
      r.cout = ua >= (ub + uc);
      sr     = sa - sb - sc;
    end
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  int           n_in = 0;
  int           n_out = 0;
  logic         prev_stall = 1'b0;
  logic [W:0]   held;

  // Handshakes seen at the negedge complete at the following posedge.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("hold_out", {cout, sum}, held);
        if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
        prev_stall = out_valid && !out_ready;
        held       = {cout, sum};
        if (out_valid && out_ready) begin
          n_out++;
          chk("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk("sum", sum, r.sum);
            chk("cout", cout, r.cout);
`ifdef OVERFLOW_FLAG_EN
            chk("ovf", ovf, r.ovf);
`endif
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(a, b, cin, sub));
          n_in++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ops;
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec,
                          input string tag);
    int lat;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk({tag, "_lat"}, lat, S);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, sent, stall_seen, n_before;
    logic acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    d8_in_valid = 1'b0; d8_out_ready = 1'b1; d8_a = '0; d8_b = '0; d8_cin = 1'b0; d8_sub = 1'b0;
    repeat (3) tick;
    rst = 1'b0;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_d8_out_valid", d8_out_valid, 0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_ovf", ovf, 0);
`endif

    send_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, "ripple_cin");
    tick;
    send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, "ones_plus1");
    tick;
    send_one(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, "sub_borrow");
    tick;
    send_one(32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, "sub_pos");
    tick;
    send_one(32'd7, 32'd5, 1'b1, 1'b1, 32'd1, 1'b1, "sub_bin");
    tick;
`ifdef OVERFLOW_FLAG_EN
    send_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, "ovf_pos");
    chk("ovf_pos_flag", ovf, 1);
    tick;
    send_one(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, "ovf_neg");
    chk("ovf_neg_flag", ovf, 1);
    tick;
    send_one(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, "ovf_none");
    chk("ovf_none_flag", ovf, 0);
    tick;
`endif

    // 8-bit, 2-stage instance
    chk("d8_in_ready", d8_in_ready, 1);
    d8_a = 8'h98; d8_b = 8'hAA; d8_cin = 1'b0; d8_sub = 1'b0; d8_in_valid = 1'b1;
    tick;
    d8_in_valid = 1'b0;
    lat = 1;
    while (!d8_out_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("d8_lat", lat, S8);
    chk("d8_sum", d8_sum, 8'h42);
    chk("d8_cout", d8_cout, 1);
    tick;

    // 16 back-to-back beats with a 3-cycle output stall in the middle
    in_valid = 1'b1;
    randomize_ops;
    sent = 0; cyc = 0; stall_seen = 0;
    while (sent < 16 && cyc < 200) begin
      out_ready = !(cyc >= 6 && cyc < 9);
      #1;
      acc = in_ready;
      if (!in_ready) stall_seen++;
      tick;
      cyc++;
      if (acc) begin
        sent++;
        randomize_ops;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_sent", sent, 16);
    chk("stream_stall_cycles", stall_seen, 3);
    repeat (S + 3) tick;
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_count", n_out, n_in);

    // random valid and backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      randomize_ops;
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (S + 3) tick;
    chk("random_drained", exp_q.size(), 0);
    chk("random_count", n_out, n_in);

    // reset with three beats in flight
    in_valid = 1'b1;
    repeat (3) begin
      randomize_ops;
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    n_before = n_out;
    repeat (S + 4) tick;
    chk("midrst_no_stale", n_out, n_before);

    send_one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, "post_rst");
    tick;
    repeat (2) tick;
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES ripple segments with a register between each, so wide adders close timing.
- Valid/ready handshake on both sides and a carry-in/carry-out chain.
- Used as the arithmetic datapath primitive feeding accumulators and ALU lanes.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥ 2.
STAGES, 4, pipeline segments; WIDTH % STAGES == 0 (elaboration error otherwise); SEG = WIDTH/STAGES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (borrow-in when sub=1)
sub  input  1  0: A+B+cin; 1: A-B-cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry-out (add); NOT borrow (sub)

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits cleared, sum=0, cout=0, out_valid=0. A reset mid-operation discards all in-flight beats; there is no partial drain. in_ready is 1 in the cycle after reset.
- Accept: a beat is accepted on a clk edge when in_valid && in_ready.
- Stall: the pipeline stalls as a whole. stall = out_valid && !out_ready. in_ready = !stall, which is combinational from out_ready. While stalled, every stage register holds.
- Bubbles are not compressed. A bubble advances like data, with its valid bit = 0.
- Operand conditioning at accept: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin.
  - sub=1 gives A + ~B + ~cin, which equals A - B - cin mod 2^WIDTH.
- Stage k (0..STAGES-1):
  - Computes bits [k*SEG +: SEG] as a SEG-bit ripple of a, b_eff and the carry registered by stage k-1 (c_eff for k=0).
  - Registers the segment sum, the segment carry-out, the already-computed lower sum bits and the untouched upper operand bits, plus a valid bit.
- Latency: exactly STAGES cycles from accept edge to out_valid=1 with no stall. With continuous valid and out_ready=1, throughput is 1 beat/cycle.
- Output: sum and cout are the final stage registers. They stay stable while out_valid && !out_ready.
- Arithmetic: sum = (a + b_eff + c_eff)[WIDTH-1:0], cout = bit WIDTH of that total. No saturation.
- Boundary cases:
  - Carry ripples across every segment boundary; all-ones + 1 → sum=0, cout=1.
  - STAGES=1 degenerates to a single registered ripple adder with latency 1.
  - Simultaneous output handshake and input accept in the same cycle is allowed; no beat is lost or duplicated.
- No combinational path from a/b/cin/sub to any output.

Optional Feature:
Macro OVERFLOW_FLAG_EN.
- Defined: adds output port ovf (1 bit), meaning signed two's-complement overflow of the result.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - It is computed in the final stage from pipelined sign bits and is aligned with out_valid.
  - Reset value 0; holds under stall.
- Not defined: port ovf is absent and no sign-bit registers exist. All other behaviour is identical.

Decomposition:
- Shared package adder_pkg:
  - function seg_count(width, stages), returning WIDTH/STAGES.
  - typedef for the stage payload struct {sum_lo, a_hi, b_hi, carry, valid}, parametrised via localparams in the module.
- One natural sub-module, adder_segment: a combinational SEG-bit ripple built from full-adder cells, with inputs a, b, cin and outputs sum, cout. Instantiated once per stage in a generate loop.

Test Plan:
- WIDTH=8, STAGES=2; a=0x98, b=0xAA, cin=0, sub=0, out_ready=1 → after 2 cycles sum=0x42, cout=1.
- WIDTH=32, STAGES=4; a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1 after 4 cycles (full cross-segment ripple).
- Subtract, WIDTH=32: a=5, b=7, sub=1, cin=0 → sum=0xFFFFFFFE, cout=0 (borrow); then a=7, b=5 → sum=2, cout=1.
- Back-to-back stream of 16 random beats; hold out_ready=0 for 3 cycles mid-stream → in_ready=0 during the stall, results in order, none lost or duplicated, each matches the reference model.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 and sum=0 the next cycle; no stale beat emerges later.
- OVERFLOW_FLAG_EN defined: a=0x7FFFFFFF, b=1, sub=0 → ovf=1; a=0x80000000, b=1, sub=1 → ovf=1; a=3, b=4 → ovf=0.
